// File: rtl/conv_top_system.sv
// rtl/conv_top_system.sv - streaming 2-D convolution top: output-stationary MAC driven by a loop-controller FSM
//   clk, arst_n_in          clock, asynchronous active-low reset
//   start, running,         layer control / status (fsm_done pulses with the last result)
//   fsm_done
//   a_input/a_valid/a_ready activation stream
//   b_input/b_valid/b_ready weight stream
//   data_ready              joint a/b transfer (one MAC step) this cycle
//   int_mem_we              internal result buffer written this cycle
//   out, output_valid,      registered result and its coordinates
//   output_x/y/ch
module conv_top_system #(
  parameter int IO_DATA_WIDTH      = 16,
  parameter int ACCUMULATION_WIDTH = 32,
  parameter int EXT_MEM_HEIGHT     = 256,
  parameter int EXT_MEM_WIDTH      = 32,
  parameter int FEATURE_MAP_WIDTH  = 128,
  parameter int FEATURE_MAP_HEIGHT = 128,
  parameter int INPUT_NB_CHANNELS  = 2,
  parameter int OUTPUT_NB_CHANNELS = 16,
  parameter int KERNEL_SIZE        = 3
) (
  input  logic                                    clk,
  input  logic                                    arst_n_in,
  input  logic                                    start,
  output logic                                    running,
  output logic                                    fsm_done,
  input  logic [IO_DATA_WIDTH-1:0]                a_input,
  input  logic                                    a_valid,
  output logic                                    a_ready,
  input  logic [IO_DATA_WIDTH-1:0]                b_input,
  input  logic                                    b_valid,
  output logic                                    b_ready,
  output logic                                    data_ready,
  output logic                                    int_mem_we,
  output logic signed [ACCUMULATION_WIDTH-1:0]    out,
  output logic                                    output_valid,
  output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]    output_x,
  output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0]   output_y,
  output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0]   output_ch
);

  localparam int XW = $clog2(FEATURE_MAP_WIDTH);
  localparam int YW = $clog2(FEATURE_MAP_HEIGHT);
  localparam int CW = $clog2(OUTPUT_NB_CHANNELS);
  localparam int KW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int IW = (INPUT_NB_CHANNELS > 1) ? $clog2(INPUT_NB_CHANNELS) : 1;
  localparam int AW = (EXT_MEM_HEIGHT > 1) ? $clog2(EXT_MEM_HEIGHT) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, OUTPUT} state_t;

  state_t                          state;
  logic [XW-1:0]                   x;
  logic [YW-1:0]                   y;
  logic [CW-1:0]                   och;
  logic [KW-1:0]                   ky;
  logic [KW-1:0]                   kx;
  logic [IW-1:0]                   ich;
  logic signed [ACCUMULATION_WIDTH-1:0] acc;
  logic [AW-1:0]                   wr_addr;
  logic [EXT_MEM_WIDTH-1:0]        result_mem [EXT_MEM_HEIGHT];

  logic xfer;
  logic first_tap;
  logic last_ich, last_kx, last_ky;
  logic last_och, last_x, last_y, last_out;
  logic signed [2*IO_DATA_WIDTH-1:0]      prod;
  logic signed [ACCUMULATION_WIDTH-1:0]   prod_ext;
  logic signed [ACCUMULATION_WIDTH-1:0]   acc_next;

  // Only joint transfers happen; a lone valid is left on the bus.
  assign xfer       = (state == FETCH) && a_valid && b_valid;
  assign a_ready    = xfer;
  assign b_ready    = xfer;
  assign data_ready = xfer;

  assign first_tap = (ky == '0) && (kx == '0) && (ich == '0);
  assign last_ich  = (ich == IW'(INPUT_NB_CHANNELS - 1));
  assign last_kx   = (kx == KW'(KERNEL_SIZE - 1));
  assign last_ky   = (ky == KW'(KERNEL_SIZE - 1));
  assign last_och  = (och == CW'(OUTPUT_NB_CHANNELS - 1));
  assign last_x    = (x == XW'(FEATURE_MAP_WIDTH - 1));
  assign last_y    = (y == YW'(FEATURE_MAP_HEIGHT - 1));
  assign last_out  = last_och && last_x && last_y;

  // Full-precision product, then sign-extended or truncated to the accumulator width.
  assign prod     = $signed(a_input) * $signed(b_input);
  assign prod_ext = ACCUMULATION_WIDTH'(prod);
  // The first tap of a pixel restarts the sum, so no separate clear cycle is needed.
  assign acc_next = first_tap ? prod_ext : (acc + prod_ext);

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state        <= IDLE;
      running      <= 1'b0;
      fsm_done     <= 1'b0;
      int_mem_we   <= 1'b0;
      output_valid <= 1'b0;
      out          <= '0;
      output_x     <= '0;
      output_y     <= '0;
      output_ch    <= '0;
      x            <= '0;
      y            <= '0;
      och          <= '0;
      ky           <= '0;
      kx           <= '0;
      ich          <= '0;
      acc          <= '0;
      wr_addr      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= FETCH;
            running <= 1'b1;
          end
        end
        FETCH: begin
          if (xfer) begin
            acc <= acc_next;
            if (last_ich) begin
              ich <= '0;
              if (last_kx) begin
                kx <= '0;
                if (last_ky) begin
                  // Last tap: the result registers are loaded now so they
                  // are visible during the single OUTPUT cycle.
                  ky           <= '0;
                  state        <= OUTPUT;
                  output_valid <= 1'b1;
                  int_mem_we   <= 1'b1;
                  out          <= acc_next;
                  output_x     <= x;
                  output_y     <= y;
                  output_ch    <= och;
                  fsm_done     <= last_out;
                end else begin
                  ky <= ky + 1'b1;
                end
              end else begin
                kx <= kx + 1'b1;
              end
            end else begin
              ich <= ich + 1'b1;
            end
          end
        end
        OUTPUT: begin
          output_valid <= 1'b0;
          int_mem_we   <= 1'b0;
          fsm_done     <= 1'b0;
          wr_addr      <= (wr_addr == AW'(EXT_MEM_HEIGHT - 1)) ? '0 : wr_addr + 1'b1;
          if (last_och) begin
            och <= '0;
            if (last_x) begin
              x <= '0;
              y <= last_y ? '0 : y + 1'b1;
            end else begin
              x <= x + 1'b1;
            end
          end else begin
            och <= och + 1'b1;
          end
          if (fsm_done) begin
            state   <= IDLE;
            running <= 1'b0;
          end else begin
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Result buffer: written during OUTPUT, no reset on the array itself.
  always_ff @(posedge clk) begin
    if (int_mem_we) begin
      result_mem[wr_addr] <= EXT_MEM_WIDTH'(out);
    end
  end

endmodule

// File: tb/tb_conv_top_system.sv
// tb/tb_conv_top_system.sv - self-checking bench for conv_top_system against a loop-nest reference model
module tb_conv_top_system;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int ICH  = 2;
  localparam int OCH  = 2;
  localparam int K    = 3;
  localparam int IOW  = 16;
  localparam int ACW  = 32;
  localparam int TAPS = K * K * ICH;
  localparam int NOUT = W * H * OCH;

  logic            clk = 1'b0;
  logic            arst_n_in = 1'b0;
  logic            start = 1'b0;
  logic            running, fsm_done;
  logic [IOW-1:0]  a_input = '0;
  logic            a_valid = 1'b0;
  logic            a_ready;
  logic [IOW-1:0]  b_input = '0;
  logic            b_valid = 1'b0;
  logic            b_ready;
  logic            data_ready, int_mem_we, output_valid;
  logic [ACW-1:0]  dout;
  logic [1:0]      output_x, output_y;
  logic            output_ch;

  int errors = 0;
  int checks = 0;
  int act [ICH][H][W];
  int wgt [OCH][ICH][K][K];
  logic [31:0] got [NOUT];
  logic [31:0] ref_run [NOUT];
  int first_cyc, second_cyc;

  always #5 clk = ~clk;

  conv_top_system #(
    .IO_DATA_WIDTH(IOW), .ACCUMULATION_WIDTH(ACW), .EXT_MEM_HEIGHT(64), .EXT_MEM_WIDTH(32),
    .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H), .INPUT_NB_CHANNELS(ICH),
    .OUTPUT_NB_CHANNELS(OCH), .KERNEL_SIZE(K)
  ) dut (
    .clk(clk), .arst_n_in(arst_n_in), .start(start), .running(running), .fsm_done(fsm_done),
    .a_input(a_input), .a_valid(a_valid), .a_ready(a_ready),
    .b_input(b_input), .b_valid(b_valid), .b_ready(b_ready),
    .data_ready(data_ready), .int_mem_we(int_mem_we), .out(dout), .output_valid(output_valid),
    .output_x(output_x), .output_y(output_y), .output_ch(output_ch)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Tap number idx of the layer walks y, x, och, ky, kx, ich (outer to inner).
  function automatic void tap(input int idx, output int a, output int b);
    int o, t, ci, kx, ky, co, x, y, ax, ay;
    o  = idx / TAPS;
    t  = idx % TAPS;
    ci = t % ICH;
    kx = (t / ICH) % K;
    ky = t / (ICH * K);
    co = o % OCH;
    x  = (o / OCH) % W;
    y  = o / (OCH * W);
    ax = x + kx - K / 2;
    ay = y + ky - K / 2;
    a  = (ax < 0 || ax >= W || ay < 0 || ay >= H) ? 0 : act[ci][ay][ax];
    b  = wgt[co][ci][ky][kx];
  endfunction

  function automatic logic [31:0] expect_out(input int o);
    longint s;
    int a, b;
    s = 0;
    for (int t = 0; t < TAPS; t++) begin
      tap(o * TAPS + t, a, b);
      s += longint'(a) * longint'(b);
    end
    return s[31:0];
  endfunction

  task automatic fill(input int mode);
    for (int c = 0; c < ICH; c++)
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++)
          case (mode)
            0: act[c][y][x] = 1;
            1: act[c][y][x] = -2;
            2: act[c][y][x] = -32768;
            default: act[c][y][x] = int'($urandom_range(0, 65535)) - 32768;
          endcase
    for (int o = 0; o < OCH; o++)
      for (int c = 0; c < ICH; c++)
        for (int ky = 0; ky < K; ky++)
          for (int kx = 0; kx < K; kx++)
            case (mode)
              0: wgt[o][c][ky][kx] = 1;
              1: wgt[o][c][ky][kx] = 3;
              2: wgt[o][c][ky][kx] = -32768;
              default: wgt[o][c][ky][kx] = int'($urandom_range(0, 65535)) - 32768;
            endcase
  endtask

  task automatic run_layer(input string tag, input bit stall, input int pulse_at, input int abort_at);
    int idx, outs, dones, wes, cyc, a, b;
    bit av, bv, done_seen;
    idx = 0; outs = 0; dones = 0; wes = 0; cyc = 0; done_seen = 0;
    first_cyc = -1; second_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    while (!done_seen && cyc < 6000) begin
      if (idx < NOUT * TAPS) begin
        tap(idx, a, b);
        av = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        bv = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      end else begin
        a = 0; b = 0; av = 1'b0; bv = 1'b0;
      end
      a_input = a[IOW-1:0];
      b_input = b[IOW-1:0];
      a_valid = av;
      b_valid = bv;
      #1;
      check({tag, " a_ready"}, a_ready, data_ready);
      check({tag, " b_ready"}, b_ready, data_ready);
      if (!(av && bv)) check({tag, " stall no transfer"}, data_ready, 0);
      if (data_ready) idx++;
      @(negedge clk);
      cyc++;
      start = (cyc == pulse_at);
      if (cyc == abort_at) begin
        arst_n_in = 1'b0;
        #1;
        check({tag, " abort running"}, running, 0);
        check({tag, " abort out"}, {output_valid, dout, output_x, output_y, output_ch}, 0);
        check({tag, " abort ctl"}, {fsm_done, int_mem_we, data_ready, a_ready, b_ready}, 0);
        return;
      end
      if (output_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        else if (second_cyc < 0) second_cyc = cyc;
        if (outs < NOUT) begin
          check({tag, " out"}, dout, expect_out(outs));
          check({tag, " coord"}, {output_y, output_x, output_ch},
                {2'((outs / OCH) / W), 2'((outs / OCH) % W), 1'(outs % OCH)});
          got[outs] = dout;
        end else begin
          check({tag, " extra output"}, 1, 0);
        end
        outs++;
      end
      if (int_mem_we) wes++;
      if (fsm_done) begin
        dones++;
        done_seen = 1'b1;
      end
    end
    check({tag, " done seen"}, done_seen, 1);
    check({tag, " output count"}, outs, NOUT);
    check({tag, " done count"}, dones, 1);
    check({tag, " we count"}, wes, outs);
    check({tag, " taps consumed"}, idx, NOUT * TAPS);
    @(negedge clk);
    check({tag, " idle after done"}, {running, fsm_done, output_valid}, 0);
  endtask

  initial begin
    a_valid = 1'b1;
    b_valid = 1'b1;
    repeat (3) @(negedge clk);
    arst_n_in = 1'b1;
    repeat (2) @(negedge clk);
    check("reset running", running, 0);
    check("reset out", {output_valid, dout, output_x, output_y, output_ch}, 0);
    check("reset ctl", {fsm_done, int_mem_we, data_ready, a_ready, b_ready}, 0);

    fill(0);
    run_layer("ones", 1'b0, 0, 0);
    check("ones corner", got[0], 8);
    check("ones interior ch0", got[10], 18);
    check("ones interior ch1", got[11], 18);
    check("first output cycle", first_cyc, TAPS + 1);
    check("output period", second_cyc - first_cyc, TAPS + 1);

    fill(1);
    run_layer("neg", 1'b0, 0, 0);
    check("neg interior", got[10], 64'hFFFF_FF94);

    fill(2);
    run_layer("min", 1'b0, 0, 0);
    check("min interior wrap", got[10], 64'h8000_0000);

    fill(3);
    run_layer("rand", 1'b0, 0, 0);
    for (int i = 0; i < NOUT; i++) ref_run[i] = got[i];
    run_layer("rand stall", 1'b1, 100, 0);
    begin
      int diff = 0;
      for (int i = 0; i < NOUT; i++) if (got[i] !== ref_run[i]) diff++;
      check("stall vs no-stall", diff, 0);
    end

    fill(0);
    run_layer("abort", 1'b0, 0, 25);
    repeat (2) @(negedge clk);
    arst_n_in = 1'b1;
    @(negedge clk);
    run_layer("restart", 1'b0, 0, 0);
    check("restart corner", got[0], 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_top_system.md
Name: conv_top_system

Overview:
- Top level of a streaming 2-D convolution accelerator: one output-stationary MAC with a loop-controller FSM.
- Pulls one activation (a) and one weight (b) per MAC step through valid/ready ports.
- Accumulates KERNEL_SIZE² × INPUT_NB_CHANNELS products per output pixel/channel.
- Emits each result with its (x, y, ch) coordinates and also writes it into an internal result buffer.

Parameters:
- IO_DATA_WIDTH, 16, signed width of a_input and b_input.
- ACCUMULATION_WIDTH, 32, signed accumulator and out width.
- EXT_MEM_HEIGHT, 256, depth (words) of the internal result buffer.
- EXT_MEM_WIDTH, 32, buffer word width; must be ≥ ACCUMULATION_WIDTH.
- FEATURE_MAP_WIDTH, 128, output/input map width (x).
- FEATURE_MAP_HEIGHT, 128, output/input map height (y).
- INPUT_NB_CHANNELS, 2, input channels.
- OUTPUT_NB_CHANNELS, 16, output channels.
- KERNEL_SIZE, 3, odd square kernel size.

Ports:
- clk  in  1  single clock; all state on rising edge.
- arst_n_in  in  1  asynchronous active-low reset.
- start  in  1  begin one full layer (sampled in IDLE only).
- running  out  1  high from accepted start until layer completes.
- fsm_done  out  1  one-cycle pulse when last output is emitted.
- a_input  in  IO_DATA_WIDTH  signed activation.
- a_valid  in  1  a_input valid.
- a_ready  out  1  DUT consumes a_input this cycle.
- b_input  in  IO_DATA_WIDTH  signed weight.
- b_valid  in  1  b_input valid.
- b_ready  out  1  DUT consumes b_input this cycle.
- data_ready  out  1  a MAC step (joint a/b transfer) occurs this cycle.
- int_mem_we  out  1  result buffer written this cycle.
- out  out  ACCUMULATION_WIDTH  signed result.
- output_valid  out  1  out/coordinates valid (one cycle per result).
- output_x  out  $clog2(FEATURE_MAP_WIDTH)  x of result.
- output_y  out  $clog2(FEATURE_MAP_HEIGHT)  y of result.
- output_ch  out  $clog2(OUTPUT_NB_CHANNELS)  output channel of result.

Behaviour:
- Reset (async assert, sync deassert): state=IDLE, all counters=0, accumulator=0.
  - All outputs 0: running, fsm_done, a_ready, b_ready, data_ready, int_mem_we, output_valid, out, output_x/y/ch.
  - Reset mid-layer aborts the layer immediately; no done pulse.
- Loop nest, outer→inner: y, x, och, ky, kx, ich.
  - Step consumes activation at (ich, x+kx−K/2, y+ky−K/2) and weight (och, ich, ky, kx).
  - Producer supplies 0 for out-of-map activations; the DUT requests every tap, padded or not.
- IDLE: start=1 → FETCH next cycle; running=1 from that edge. start while running is ignored.
- FETCH: a_ready = b_ready = data_ready = a_valid & b_valid. Only joint transfers occur; a valid without the other is not consumed.
  - On transfer: acc ← (first tap ? 0 : acc) + a·b.
  - Product is a full 2·IO_DATA_WIDTH signed value, sign-extended/truncated to ACCUMULATION_WIDTH. Accumulation wraps two's-complement, no saturation.
  - Inner counters advance. After the last tap (ky, kx, ich all max) → OUTPUT.
- OUTPUT (exactly one cycle): output_valid=1, int_mem_we=1, out=acc, coordinates=current (x, y, och).
  - Buffer[wr_addr] ← sign-extended acc; wr_addr increments modulo EXT_MEM_HEIGHT.
  - Outer counters advance: och fastest, then x, then y.
  - If the layer is finished: fsm_done=1 the same cycle, → IDLE, running=0 on the next edge. Else → FETCH.
- Latency:
  - A result appears 1 cycle after its last tap transfer.
  - With a/b always valid, each output takes K²·INPUT_NB_CHANNELS+1 cycles.
  - Total outputs per layer: W·H·OUTPUT_NB_CHANNELS.
- out, coordinates and output_valid are registered, and hold their values while output_valid=0.

Test Plan:
- Reset with start=0 → all outputs 0; running stays 0; no ready asserted.
- Default params, a=1 and b=1 always valid (0 at padded taps):
  - (0,0,0) out=8, (1,1,any ch) out=18.
  - First output_valid 19 cycles after the FETCH entry edge.
  - fsm_done after 262144 outputs.
- a=−2, b=3 interior → out=−108; a=b=−32768 interior → out=18·2^30 wrapped to 32 bits = 0x80000000.
- Randomly deassert a_valid or b_valid independently → no transfer unless both high; results identical to the no-stall run.
- Assert arst_n_in low mid-layer → outputs zero immediately.
  - After release, a new start restarts at (0,0,0) with a fresh accumulator.
- Pulse start while running → ignored; exactly one fsm_done per layer.
  - int_mem_we count equals the output_valid count.
